// File: rtl/rsc2_ntable_pkg.sv
// Shared constants for the RSC2 packet-length lookup: DVB-RCS couple sizes
// indexed by packet type, plus helpers that resolve reserved codes.
package rsc2_ntable_pkg;

  localparam int cPTYPE_NUM = 12;

  localparam logic [12:0] cN_DEFAULT = 13'd48;

  localparam logic [12:0] cN_TABLE [cPTYPE_NUM] = '{
    13'd48,  13'd64,  13'd212, 13'd220,
    13'd228, 13'd424, 13'd432, 13'd440,
    13'd752, 13'd848, 13'd856, 13'd864
  };

  function automatic logic is_reserved(input logic [5:0] ptype);
    return (ptype >= 6'(cPTYPE_NUM));
  endfunction

  // Reserved codes fall back to the smallest block so downstream address
  // counters always see a legal edge.
  function automatic logic [12:0] get_n(input logic [5:0] ptype);
    logic [12:0] n;
    if (is_reserved(ptype)) begin
      n = cN_DEFAULT;
    end else begin
      n = cN_TABLE[ptype[3:0]];
    end
    return n;
  endfunction

endpackage

// File: rtl/rsc2_ntable.sv
// Packet-type to block length (N, N-1) lookup for the RSC2 decoder source.
// Define RSC2_NTABLE_COMB_EN for a purely combinational, zero-latency version.
module rsc2_ntable
  import rsc2_ntable_pkg::*;
#(
  parameter int pN_W = 13
) (
  input  logic            iclk,
  input  logic            ireset,
  input  logic            iclkena,
  input  logic [5:0]      iptype,
  output logic [pN_W-1:0] oN,
  output logic [pN_W-1:0] oNm1,
  output logic            oerr
);

  logic [pN_W-1:0] n_d;
  logic [pN_W-1:0] nm1_d;
  logic            err_d;

  always_comb begin
    n_d   = pN_W'(get_n(iptype));
    nm1_d = n_d - pN_W'(1);
    err_d = is_reserved(iptype);
  end

`ifdef RSC2_NTABLE_COMB_EN

  // Clock, reset and enable have no role when the lookup is combinational.
  logic unused_ok;
  assign unused_ok = ^{iclk, ireset, iclkena};

  assign oN   = n_d;
  assign oNm1 = nm1_d;
  assign oerr = err_d;

`else

  logic [pN_W-1:0] n_q;
  logic [pN_W-1:0] nm1_q;
  logic            err_q;

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      n_q   <= pN_W'(cN_DEFAULT);
      nm1_q <= pN_W'(cN_DEFAULT) - pN_W'(1);
      err_q <= 1'b0;
    end else if (iclkena) begin
      n_q   <= n_d;
      nm1_q <= nm1_d;
      err_q <= err_d;
    end
  end

  assign oN   = n_q;
  assign oNm1 = nm1_q;
  assign oerr = err_q;

`endif

endmodule

// File: tb/tb_rsc2_ntable.sv
// Directed, table-driven bench for rsc2_ntable; covers reset, sweep, reserved
// codes, enable hold, back-to-back changes and the combinational build.
`timescale 1ns/1ps
module tb_rsc2_ntable;

  localparam int W = 13;

  typedef struct {
    logic [5:0]   ptype;
    logic         en;
    logic [W-1:0] exp_n;
    logic         exp_err;
  } vec_t;

  logic         iclk = 1'b0;
  logic         ireset;
  logic         iclkena;
  logic [5:0]   iptype;
  logic [W-1:0] oN;
  logic [W-1:0] oNm1;
  logic         oerr;

  int checks = 0;
  int errors = 0;

  vec_t vecs [27];
  logic [W-1:0] exp_q [$];

  rsc2_ntable #(.pN_W(W)) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .iptype  (iptype),
    .oN      (oN),
    .oNm1    (oNm1),
    .oerr    (oerr)
  );

  // Clock / reset block
  always #5 iclk = ~iclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] n, input logic err);
    check({tag, " oN"}, 32'(oN), 32'(n));
    check({tag, " oNm1"}, 32'(oNm1), 32'(n - W'(1)));
    check({tag, " oerr"}, 32'(oerr), 32'(err));
  endtask

  task automatic drive(input logic [5:0] p, input logic en);
    iptype  = p;
    iclkena = en;
  endtask

  task automatic fill_table();
    logic [W-1:0] nt [12];
    nt = '{13'd48, 13'd64, 13'd212, 13'd220, 13'd228, 13'd424,
           13'd432, 13'd440, 13'd752, 13'd848, 13'd856, 13'd864};
    for (int i = 0; i < 12; i++) vecs[i] = '{6'(i), 1'b1, nt[i], 1'b0};
    vecs[12] = '{6'd12, 1'b1, 13'd48,  1'b1};
    vecs[13] = '{6'd40, 1'b1, 13'd48,  1'b1};
    vecs[14] = '{6'd63, 1'b1, 13'd48,  1'b1};
    // enable hold: 864 survives iptype moving to 2 while disabled
    vecs[15] = '{6'd11, 1'b1, 13'd864, 1'b0};
    vecs[16] = '{6'd2,  1'b0, 13'd864, 1'b0};
    vecs[17] = '{6'd2,  1'b0, 13'd864, 1'b0};
    vecs[18] = '{6'd2,  1'b1, 13'd212, 1'b0};
    vecs[19] = '{6'd0,  1'b1, 13'd48,  1'b0};
    vecs[20] = '{6'd1,  1'b1, 13'd64,  1'b0};
    vecs[21] = '{6'd2,  1'b1, 13'd212, 1'b0};
    vecs[22] = '{6'd3,  1'b1, 13'd220, 1'b0};
    // reserved then hold with enable low: err must hold too
    vecs[23] = '{6'd50, 1'b1, 13'd48,  1'b1};
    vecs[24] = '{6'd7,  1'b0, 13'd48,  1'b1};
    vecs[25] = '{6'd7,  1'b1, 13'd440, 1'b0};
    vecs[26] = '{6'd63, 1'b1, 13'd48,  1'b1};
  endtask

  initial begin
    fill_table();
    ireset  = 1'b1;
    iclkena = 1'b1;
    iptype  = 6'd5;

`ifdef RSC2_NTABLE_COMB_EN
    #1;
    check_out("comb p5 under reset", 13'd424, 1'b0);
    foreach (vecs[i]) begin
      iptype = vecs[i].ptype;
      #1;
      exp_q.push_back(get_exp_n(vecs[i].ptype));
      check_out($sformatf("comb p%0d", vecs[i].ptype), exp_q.pop_front(),
                vecs[i].ptype >= 6'd12);
    end
    ireset  = 1'b0;
    iclkena = 1'b0;
    iptype  = 6'd8;
    #1;
    check_out("comb p8", 13'd752, 1'b0);
    repeat (2) @(posedge iclk);
    #1;
    check_out("comb p8 after clocks", 13'd752, 1'b0);
`else
    // Reset asserted with no clock edge yet
    #1;
    check_out("reset async", 13'd48, 1'b0);
    repeat (2) @(posedge iclk);
    #1;
    check_out("reset held over edges", 13'd48, 1'b0);
    @(negedge iclk);
    ireset = 1'b0;
    #1;
    check_out("release no edge", 13'd48, 1'b0);
    @(posedge iclk);
    #1;
    check_out("first edge p5", 13'd424, 1'b0);

    // Table: drive at negedge, confirm one-cycle lag, then check after edge
    begin
      logic [W-1:0] prev_n;
      logic         prev_err;
      prev_n   = 13'd424;
      prev_err = 1'b0;
      foreach (vecs[i]) begin
        @(negedge iclk);
        drive(vecs[i].ptype, vecs[i].en);
        exp_q.push_back(vecs[i].exp_n);
        #1;
        check_out($sformatf("v%0d pre-edge", i), prev_n, prev_err);
        @(posedge iclk);
        #1;
        check_out($sformatf("v%0d p%0d", i, vecs[i].ptype), exp_q.pop_front(), vecs[i].exp_err);
        prev_n   = vecs[i].exp_n;
        prev_err = vecs[i].exp_err;
      end
    end

    // Mid-operation reset after a reserved load (oerr=1) overrides enable/iptype
    @(negedge iclk);
    drive(6'd9, 1'b1);
    ireset = 1'b1;
    #1;
    check_out("mid reset async", 13'd48, 1'b0);
    @(posedge iclk);
    #1;
    check_out("mid reset held", 13'd48, 1'b0);
    @(negedge iclk);
    ireset = 1'b0;
    @(posedge iclk);
    #1;
    check_out("post reset p9", 13'd848, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [W-1:0] get_exp_n(input logic [5:0] p);
    logic [W-1:0] nt [12];
    nt = '{13'd48, 13'd64, 13'd212, 13'd220, 13'd228, 13'd424,
           13'd432, 13'd440, 13'd752, 13'd848, 13'd856, 13'd864};
    return (p < 6'd12) ? nt[p[3:0]] : 13'd48;
  endfunction

endmodule
